// File: rtl/mod_out_select_if.sv
// Sample inputs, mode-change handshake and DAC output of mod_out_select.
// master = stream/controller side, slave = mod_out_select.
interface mod_out_select_if #(
  parameter int DATA_W = 8
);
  logic signed [DATA_W-1:0] in_sine;
  logic signed [DATA_W-1:0] in_ask;
  logic signed [DATA_W-1:0] in_psk;
  logic signed [DATA_W-1:0] in_am;
  logic signed [DATA_W-1:0] in_fm;
  logic [1:0]               gain_shift;
  logic [2:0]               req_mode;
  logic                     req_valid;
  logic                     req_ready;
  logic [2:0]               mode_cur;
  logic                     mode_ack;
  logic                     mode_err;
  logic                     timeout_flag;
  logic [DATA_W-1:0]        dac_data;

  modport master (
    output in_sine, in_ask, in_psk, in_am, in_fm, gain_shift, req_mode, req_valid,
    input  req_ready, mode_cur, mode_ack, mode_err, timeout_flag, dac_data
  );

  modport slave (
    input  in_sine, in_ask, in_psk, in_am, in_fm, gain_shift, req_mode, req_valid,
    output req_ready, mode_cur, mode_ack, mode_err, timeout_flag, dac_data
  );
endinterface

// File: rtl/mod_out_select.sv
// Selects one modulated stream, switches modes at a zero crossing (or after a
// bounded wait) and drives an attenuated offset-binary DAC word.
//
// state | meaning
// RUN   | streaming; mode-change requests accepted
// PEND  | target latched, waiting for a zero crossing or the wait limit
module mod_out_select #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  mod_out_select_if.slave bus
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  localparam logic [15:0]       WAIT_TC  = 16'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  state_t                   state_q, state_d;
  logic [2:0]               mode_q, mode_d;
  logic [2:0]               target_q, target_d;
  logic [15:0]              wait_q, wait_d;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;
  logic                     to_q, to_d;
  logic signed [DATA_W-1:0] sel;
  logic signed [DATA_W-1:0] prev_s;
  logic signed [DATA_W-1:0] s1;
  logic [DATA_W-1:0]        dac_q;
  logic                     zc;

  always_comb begin
    sel = bus.in_sine;
    case (mode_q)
      3'd0:    sel = bus.in_sine;
      3'd1:    sel = bus.in_ask;
      3'd2:    sel = bus.in_psk;
      3'd3:    sel = bus.in_am;
      3'd4:    sel = bus.in_fm;
      default: sel = bus.in_sine;
    endcase
  end

  // Zero crossing is judged on the raw stream, never on the attenuated one.
  assign zc = (sel[DATA_W-1] != prev_s[DATA_W-1]) || (sel == '0);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    target_d = target_q;
    wait_d   = wait_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    to_d     = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.req_valid) begin
          if (bus.req_mode > 3'd4) begin
            err_d = 1'b1;
          end else if (bus.req_mode == mode_q) begin
            ack_d = 1'b1;
          end else begin
            target_d = bus.req_mode;
            wait_d   = '0;
            state_d  = PEND;
          end
        end
      end
      PEND: begin
        if (zc) begin
          mode_d  = target_q;
          ack_d   = 1'b1;
          state_d = RUN;
        end else if (wait_q == WAIT_TC) begin
          mode_d  = target_q;
          ack_d   = 1'b1;
          to_d    = 1'b1;
          state_d = RUN;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      mode_q   <= 3'd0;
      target_q <= 3'd0;
      wait_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      target_q <= target_d;
      wait_q   <= wait_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_s <= '0;
      s1     <= '0;
      dac_q  <= MIDSCALE;
    end else begin
      prev_s <= sel;
      s1     <= sel >>> bus.gain_shift;
      dac_q  <= {~s1[DATA_W-1], s1[DATA_W-2:0]};
    end
  end

  assign bus.req_ready    = (state_q == RUN);
  assign bus.mode_cur     = mode_q;
  assign bus.mode_ack     = ack_q;
  assign bus.mode_err     = err_q;
  assign bus.timeout_flag = to_q;
  assign bus.dac_data     = dac_q;

endmodule

// File: tb/tb_mod_out_select.sv
// Directed bench for mod_out_select with TIMEOUT=16: reset, datapath mapping,
// illegal/same-mode requests, zero-crossing switch, timeout and priority.
module tb_mod_out_select;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  mod_out_select_if #(.DATA_W(8)) bus ();

  mod_out_select #(.DATA_W(8), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic dp(input logic [7:0] smp, input logic [1:0] g, input logic [7:0] exp,
                    input string tag);
    bus.in_sine    = smp;
    bus.gain_shift = g;
    tick();
    tick();
    check(tag, 32'(bus.dac_data), 32'(exp));
  endtask

  initial begin
    int  n;
    logic seen;
    n_assert = 0;
    n_fail   = 0;
    rst_n          = 1'b0;
    bus.in_sine    = '0;
    bus.in_ask     = '0;
    bus.in_psk     = '0;
    bus.in_am      = '0;
    bus.in_fm      = '0;
    bus.gain_shift = 2'd0;
    bus.req_mode   = 3'd0;
    bus.req_valid  = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_dac",      32'(bus.dac_data), 32'h80);
    check("rst_mode",     32'(bus.mode_cur), 32'd0);
    check("rst_ack",      32'(bus.mode_ack), 32'd0);
    check("rst_err",      32'(bus.mode_err), 32'd0);
    check("rst_to",       32'(bus.timeout_flag), 32'd0);
    rst_n = 1'b1;
    check("ready_after_rst", 32'(bus.req_ready), 32'd1);

    // Datapath mapping and 2-cycle latency
    dp(8'h80, 2'd0, 8'h00, "dp_m128_g0");
    dp(8'h00, 2'd0, 8'h80, "dp_0_g0");
    bus.in_sine = 8'h7F;
    tick();
    check("dp_latency_1cyc", 32'(bus.dac_data), 32'h80);
    tick();
    check("dp_127_g0", 32'(bus.dac_data), 32'hFF);
    dp(8'h80, 2'd2, 8'h60, "dp_m128_g2");
    dp(8'h7F, 2'd3, 8'h8F, "dp_127_g3");
    bus.gain_shift = 2'd0;

    // Illegal mode
    bus.req_mode  = 3'd6;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check("ill_err",   32'(bus.mode_err), 32'd1);
    check("ill_mode",  32'(bus.mode_cur), 32'd0);
    check("ill_ready", 32'(bus.req_ready), 32'd1);
    check("ill_ack",   32'(bus.mode_ack), 32'd0);
    tick();
    check("ill_err_pulse", 32'(bus.mode_err), 32'd0);

    // Same-mode request
    bus.req_mode  = 3'd0;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check("same_ack",   32'(bus.mode_ack), 32'd1);
    check("same_ready", 32'(bus.req_ready), 32'd1);
    tick();
    check("same_ack_pulse", 32'(bus.mode_ack), 32'd0);

    // Zero-crossing switch to psk
    bus.in_sine = 8'd5;
    bus.in_psk  = 8'd20;
    tick();
    tick();
    bus.req_mode  = 3'd2;
    bus.req_valid = 1'b1;
    tick();
    check("zc_ready_pend", 32'(bus.req_ready), 32'd0);
    bus.req_mode = 3'd6;
    tick();
    bus.req_valid = 1'b0;
    check("zc_ignored_req", 32'(bus.mode_err), 32'd0);
    check("zc_no_ack_yet",  32'(bus.mode_ack), 32'd0);
    tick();
    check("zc_ready_pend2", 32'(bus.req_ready), 32'd0);
    bus.in_sine = 8'hFD;
    tick();
    check("zc_ack",   32'(bus.mode_ack), 32'd1);
    check("zc_mode",  32'(bus.mode_cur), 32'd2);
    check("zc_to",    32'(bus.timeout_flag), 32'd0);
    check("zc_ready", 32'(bus.req_ready), 32'd1);
    tick();
    check("zc_ack_pulse", 32'(bus.mode_ack), 32'd0);
    check("zc_dac_old",   32'(bus.dac_data), 32'h7D);
    tick();
    check("zc_dac_new",   32'(bus.dac_data), 32'h94);

    // Timeout switch to fm
    bus.in_psk    = 8'd5;
    bus.in_fm     = 8'd5;
    bus.req_mode  = 3'd4;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    do begin
      n++;
      tick();
      if (!bus.req_ready && bus.mode_ack) seen = 1'b1;
    end while (!bus.req_ready && n < 100);
    check("to_pend_cycles", 32'(n), 32'd16);
    check("to_early_ack",   32'(seen), 32'd0);
    check("to_ack",  32'(bus.mode_ack), 32'd1);
    check("to_flag", 32'(bus.timeout_flag), 32'd1);
    check("to_mode", 32'(bus.mode_cur), 32'd4);
    tick();
    check("to_ack_pulse",  32'(bus.mode_ack), 32'd0);
    check("to_flag_pulse", 32'(bus.timeout_flag), 32'd0);

    // Zero crossing on the timeout edge wins
    bus.req_mode  = 3'd1;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.mode_ack || bus.req_ready) seen = 1'b1;
    end
    check("pri_wait", 32'(seen), 32'd0);
    bus.in_fm = 8'hF9;
    tick();
    check("pri_ack",  32'(bus.mode_ack), 32'd1);
    check("pri_to",   32'(bus.timeout_flag), 32'd0);
    check("pri_mode", 32'(bus.mode_cur), 32'd1);

    // Reset mid-PEND abandons the request
    bus.in_ask = 8'd5;
    tick();
    tick();
    bus.req_mode  = 3'd3;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check("rpend_ready", 32'(bus.req_ready), 32'd0);
    tick();
    rst_n = 1'b0;
    #2;
    check("rpend_dac",   32'(bus.dac_data), 32'h80);
    check("rpend_mode",  32'(bus.mode_cur), 32'd0);
    check("rpend_ready", 32'(bus.req_ready), 32'd1);
    check("rpend_ack",   32'(bus.mode_ack), 32'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.mode_ack || bus.timeout_flag) seen = 1'b1;
    end
    check("rpend_no_ack",  32'(seen), 32'd0);
    check("rpend_mode2",   32'(bus.mode_cur), 32'd0);

    // Zero crossing by a sample equal to zero
    bus.in_sine = 8'd5;
    tick();
    tick();
    bus.req_mode  = 3'd3;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check("z0_pend", 32'(bus.req_ready), 32'd0);
    bus.in_sine = 8'd0;
    tick();
    check("z0_ack",  32'(bus.mode_ack), 32'd1);
    check("z0_to",   32'(bus.timeout_flag), 32'd0);
    check("z0_mode", 32'(bus.mode_cur), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_out_select.md
MOD_OUT_SELECT -- requirements
Module: mod_out_select

Sits downstream of the sine/ASK/PSK/AM/FM generators. It selects one modulated stream, switches modes glitch-free at a zero crossing, and drives an offset-binary DAC word.

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the sample width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, giving the maximum number of cycles spent waiting for a zero crossing (legal range 2..65535).

Ports:
REQ-003 clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_sine, in_ask, in_psk, in_am, in_fm  input  DATA_W each  signed two's-complement samples, one new sample per clk.
REQ-006 gain_shift  input  2  attenuation, applied as an arithmetic right shift of 0..3 bits.
REQ-007 req_mode  input  3  requested mode: 0=sine, 1=ask, 2=psk, 3=am, 4=fm; values 5..7 are illegal.
REQ-008 req_valid  input  1  mode-change request is valid.
REQ-009 req_ready  output  1  block can accept a request; high only in state RUN.
REQ-010 mode_cur  output  3  currently selected mode.
REQ-011 mode_ack  output  1  one-cycle pulse when a switch completes.
REQ-012 mode_err  output  1  one-cycle pulse when an illegal mode is rejected.
REQ-013 timeout_flag  output  1  one-cycle pulse, coincident with mode_ack, when a switch was forced by timeout.
REQ-014 dac_data  output  DATA_W  offset-binary DAC word.

Function
REQ-015 The FSM SHALL have two states: RUN and PEND.
REQ-016 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; with req_ready=0 the request SHALL be ignored with no side effects.
REQ-017 On acceptance with illegal req_mode, the FSM SHALL stay in RUN, mode_err SHALL pulse in the next cycle, and mode_cur SHALL be unchanged.
REQ-018 On acceptance with req_mode == mode_cur, the FSM SHALL stay in RUN and mode_ack SHALL pulse in the next cycle.
REQ-019 Otherwise on acceptance: the target mode SHALL be latched, the wait counter cleared to 0, and the state set to PEND.
REQ-020 A zero crossing is defined as (sign bit of the raw current-stream sample != sign bit of prev_s) OR (raw current-stream sample == 0).
REQ-021 prev_s SHALL register the raw (unshifted) selected-stream sample every cycle, in all states.
REQ-022 In PEND, on an edge with a zero crossing: mode_cur SHALL load the target, mode_ack SHALL pulse in the following cycle, and the state SHALL return to RUN.
REQ-023 In PEND with no zero crossing and wait counter == TIMEOUT-1: the switch SHALL be forced exactly as in REQ-022, and timeout_flag SHALL pulse together with mode_ack.
REQ-024 In PEND with no zero crossing and wait counter < TIMEOUT-1: the wait counter SHALL increment by 1.
REQ-025 If a zero crossing and the timeout condition occur on the same edge, the zero crossing SHALL take priority and timeout_flag SHALL remain 0.
REQ-026 Output pipeline stage 1 SHALL register s1 = (selected raw sample) >>> gain_shift, arithmetic, with sign preserved.
REQ-027 Output pipeline stage 2 SHALL register dac_data = s1 with its MSB inverted (offset binary).
REQ-028 Latency from a sample on an input port to dac_data SHALL be exactly 2 cycles.
REQ-029 The stream select SHALL follow mode_cur, so the new stream appears on dac_data 2 cycles after mode_cur changes.
REQ-030 Full-scale mapping (DATA_W=8, gain_shift=0): -128 SHALL give 0x00, 0 SHALL give 0x80, 127 SHALL give 0xFF.

Reset
REQ-031 While rst_n=0, asynchronously: state=RUN, mode_cur=0, prev_s=0, s1=0, dac_data=midscale (0x80 for DATA_W=8), wait counter=0, mode_ack=0, mode_err=0, timeout_flag=0.
REQ-032 Assertion of rst_n in PEND SHALL abandon the pending request with no ack.
REQ-033 req_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-034 Reset: assert rst_n=0 mid-PEND -> dac_data=0x80, mode_cur=0, req_ready=1, no mode_ack pulse.
REQ-035 Zero-crossing switch: in_sine held at +5; request mode 2 at edge N; in_sine set to -3 at edge N+3 -> mode_ack pulses one cycle after that edge, mode_cur=2, timeout_flag=0, req_ready=0 during PEND.
REQ-036 Timeout: TIMEOUT=16, in_sine held at +5, request mode 4 -> exactly 16 cycles in PEND, then mode_ack=1 and timeout_flag=1 for one cycle, mode_cur=4.
REQ-037 Illegal and same-mode requests: req_mode=6 -> mode_err pulse with mode_cur unchanged; req_mode equal to mode_cur -> mode_ack pulse the next cycle with no PEND.
REQ-038 Datapath: gain_shift=0 with -128, 0, 127 -> 0x00, 0x80, 0xFF after 2 cycles; gain_shift=2 with -128 -> 0x60; gain_shift=3 with 127 -> 0x8F.
REQ-039 Priority: zero crossing and counter == TIMEOUT-1 on the same edge -> mode_ack=1 and timeout_flag=0.
